// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl
// Purpose  : Command-driven sequencer for an n-bit LFSR. It issues seed loads
//            and step enables, runs bounded or free-running step bursts, and
//            streams each new LFSR value over a valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    output logic          lfsr_load,
    output logic [N-1:0]  lfsr_seed,
    output logic          lfsr_en,
    input  logic [N-1:0]  lfsr_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] steps_done,
    output logic          lockup
);

    localparam logic [1:0] c_OP_STOP   = 2'b00;
    localparam logic [1:0] c_OP_LOAD   = 2'b01;
    localparam logic [1:0] c_OP_STEP_N = 2'b10;
    localparam logic [1:0] c_OP_RUN    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_remaining;
    logic          w_cmd_fire;
    logic          w_idle_ready;
    logic          w_burst_ready;

    // A LOAD waits in IDLE until any pending sample drains, so the consumer
    // never sees a sample belonging to the previous seed change underneath it.
    assign w_idle_ready  = (r_state == ST_IDLE) && ((cmd_op != c_OP_LOAD) || !out_valid);
    assign w_burst_ready = ((r_state == ST_STEP) || (r_state == ST_RUN)) && (cmd_op == c_OP_STOP);
    assign cmd_ready     = reset && (w_idle_ready || w_burst_ready);
    assign w_cmd_fire    = cmd_valid && cmd_ready;

    assign lfsr_en  = ((r_state == ST_RUN) || ((r_state == ST_STEP) && (r_remaining != '0)))
                      && (!out_valid || out_ready);
    assign out_data = lfsr_q;
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            lfsr_load   <= 1'b0;
            lfsr_seed   <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            steps_done  <= '0;
            lockup      <= 1'b0;
        end else begin
            done      <= 1'b0;
            lfsr_load <= 1'b0;

            if (lfsr_en) begin
                out_valid <= 1'b1;
                if (steps_done != '1) begin
                    steps_done <= steps_done + 1'b1;
                end
                if (lfsr_q == '0) begin
                    lockup <= 1'b1;
                end
                if (r_state == ST_STEP) begin
                    r_remaining <= r_remaining - 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        case (cmd_op)
                            c_OP_LOAD: begin
                                r_state   <= ST_LOAD;
                                lfsr_load <= 1'b1;
                                lfsr_seed <= cmd_data;
                                lockup    <= 1'b0;
                            end
                            c_OP_STEP_N: begin
                                r_remaining <= cmd_data[CW-1:0];
                                steps_done  <= '0;
                                if (cmd_data[CW-1:0] != '0) begin
                                    r_state <= ST_STEP;
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                            c_OP_RUN: begin
                                steps_done <= '0;
                                r_state    <= ST_RUN;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_IDLE;
                end
                ST_STEP: begin
                    // A STOP on the final step still issues it but suppresses done.
                    if (w_cmd_fire) begin
                        r_state <= ST_IDLE;
                    end else if (lfsr_en && (r_remaining == CW'(1))) begin
                        r_state <= ST_IDLE;
                        done    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_cmd_fire) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_ctrl
// Purpose  : Directed self-checking bench for lfsr_seq_ctrl with a local
//            32-bit Fibonacci LFSR (taps 32,22,2,1) feeding lfsr_q.
// Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_seq_ctrl;

    localparam int N  = 32;
    localparam int CW = 16;

    localparam logic [1:0] c_OP_STOP   = 2'b00;
    localparam logic [1:0] c_OP_LOAD   = 2'b01;
    localparam logic [1:0] c_OP_STEP_N = 2'b10;
    localparam logic [1:0] c_OP_RUN    = 2'b11;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic          lfsr_load;
    logic [N-1:0]  lfsr_seed;
    logic          lfsr_en;
    logic [N-1:0]  lfsr_q;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_done;
    logic          lockup;

    int checks = 0;
    int errors = 0;

    int          en_count   = 0;
    int          done_count = 0;
    int          beat_cnt   = 0;
    logic [31:0] beats [0:127];

    lfsr_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .lfsr_load  (lfsr_load),
        .lfsr_seed  (lfsr_seed),
        .lfsr_en    (lfsr_en),
        .lfsr_q     (lfsr_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .steps_done (steps_done),
        .lockup     (lockup)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // LFSR register and polynomial block standing in for the datapath
    initial lfsr_q = '0;
    always @(posedge clock) begin
        if (lfsr_load) begin
            lfsr_q <= lfsr_seed;
        end else if (lfsr_en) begin
            lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end
    end

    always @(negedge clock) begin
        if (lfsr_en) en_count <= en_count + 1;
        if (done) done_count <= done_count + 1;
        if (out_valid && out_ready && beat_cnt < 128) begin
            beats[beat_cnt] <= out_data;
            beat_cnt        <= beat_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] data);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        #1;
        while (!cmd_ready && n < 50) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (!cmd_ready) begin
            check_val("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check_val("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int e0;
        int d0;
        int b0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = c_OP_STOP;
        cmd_data  = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_lfsr_en",   32'(lfsr_en),   32'd0);
        check_val("rst_busy",      32'(busy),      32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_steps",     32'(steps_done), 32'd0);
        check_val("rst_lockup",    32'(lockup),    32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        check_val("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic burst: LOAD 1, STEP_N 4
        send_cmd(c_OP_LOAD, 32'h0000_0001);
        check_val("load_strobe", 32'(lfsr_load), 32'd1);
        check_val("load_seed",   lfsr_seed,      32'h0000_0001);
        check_val("load_busy",   32'(busy),      32'd1);
        tick();
        check_val("load_strobe_off", 32'(lfsr_load), 32'd0);
        check_val("load_back_idle",  32'(busy),      32'd0);
        e0 = en_count; d0 = done_count; b0 = beat_cnt;
        send_cmd(c_OP_STEP_N, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val("burst_en_on", 32'(lfsr_en), 32'd1);
            tick();
        end
        check_val("burst_en_off", 32'(lfsr_en), 32'd0);
        check_val("burst_done",   32'(done),    32'd1);
        check_val("burst_idle",   32'(busy),    32'd0);
        tick();
        check_val("burst_done_pulse", 32'(done), 32'd0);
        tick();
        check_val("burst_steps",   32'(steps_done),  32'd4);
        check_val("burst_en_cnt",  en_count - e0,    32'd4);
        check_val("burst_done_cnt", done_count - d0, 32'd1);
        check_val("burst_beat_cnt", beat_cnt - b0,   32'd4);
        check_val("burst_beat0", beats[b0],   32'h0000_0003);
        check_val("burst_beat1", beats[b0+1], 32'h0000_0006);
        check_val("burst_beat2", beats[b0+2], 32'h0000_000D);
        check_val("burst_beat3", beats[b0+3], 32'h0000_001B);

        // Backpressure: STEP_N 3 with a 5-cycle stall after the first sample
        e0 = en_count; d0 = done_count; b0 = beat_cnt;
        send_cmd(c_OP_STEP_N, 32'd3);
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_en_stall",   32'(lfsr_en),   32'd0);
            check_val("bp_data_hold",  out_data,       32'h0000_0036);
            check_val("bp_valid_hold", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        tick();
        tick();
        check_val("bp_steps",    32'(steps_done), 32'd3);
        check_val("bp_en_cnt",   en_count - e0,   32'd3);
        check_val("bp_done_cnt", done_count - d0, 32'd1);
        check_val("bp_beat_cnt", beat_cnt - b0,   32'd3);
        check_val("bp_beat0", beats[b0],   32'h0000_0036);
        check_val("bp_beat1", beats[b0+1], 32'h0000_006D);
        check_val("bp_beat2", beats[b0+2], 32'h0000_00DB);

        // Zero count, then LOAD gated by a pending sample
        e0 = en_count;
        send_cmd(c_OP_STEP_N, 32'd0);
        check_val("zero_done",  32'(done),       32'd1);
        check_val("zero_busy",  32'(busy),       32'd0);
        check_val("zero_en",    32'(lfsr_en),    32'd0);
        check_val("zero_steps", 32'(steps_done), 32'd0);
        tick();
        check_val("zero_done_off", 32'(done),   32'd0);
        check_val("zero_en_cnt",   en_count - e0, 32'd0);
        out_ready = 1'b0;
        send_cmd(c_OP_STEP_N, 32'd1);
        tick();
        check_val("gate_valid", 32'(out_valid), 32'd1);
        check_val("gate_data",  out_data,       32'h0000_01B6);
        cmd_valid = 1'b1;
        cmd_op    = c_OP_LOAD;
        cmd_data  = 32'h0000_0000;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("gate_load_blocked", 32'(cmd_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_val("gate_still_blocked", 32'(cmd_ready), 32'd0);
        send_cmd(c_OP_LOAD, 32'h0000_0000);
        check_val("gate_load_strobe", 32'(lfsr_load), 32'd1);
        tick();

        // Lockup: stepping from the all-zero state
        send_cmd(c_OP_STEP_N, 32'd2);
        check_val("lock_clear_before", 32'(lockup), 32'd0);
        tick();
        check_val("lock_set", 32'(lockup), 32'd1);
        wait_idle();
        tick();
        check_val("lock_sticky", 32'(lockup), 32'd1);
        send_cmd(c_OP_LOAD, 32'h0000_0005);
        check_val("lock_cleared",   32'(lockup),   32'd0);
        check_val("lock_load_seed", lfsr_seed,     32'h0000_0005);
        tick();

        // STOP in IDLE is a no-op; STOP during RUN after 10 steps
        d0 = done_count;
        send_cmd(c_OP_STOP, 32'd0);
        check_val("stop_idle_busy", 32'(busy), 32'd0);
        e0 = en_count;
        send_cmd(c_OP_RUN, 32'd0);
        check_val("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check_val("run_steps_10", 32'(steps_done), 32'd10);
        send_cmd(c_OP_STOP, 32'd0);
        check_val("stop_idle",  32'(busy),       32'd0);
        check_val("stop_en",    32'(lfsr_en),    32'd0);
        check_val("stop_steps", 32'(steps_done), 32'd11);
        for (int i = 0; i < 3; i++) tick();
        check_val("stop_en_cnt",   en_count - e0,   32'd11);
        check_val("stop_no_done",  done_count - d0, 32'd0);
        check_val("stop_steps_hold", 32'(steps_done), 32'd11);

        // Asynchronous reset mid-RUN
        send_cmd(c_OP_RUN, 32'd0);
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        check_val("arst_cmd_ready", 32'(cmd_ready),  32'd0);
        check_val("arst_en",        32'(lfsr_en),    32'd0);
        check_val("arst_busy",      32'(busy),       32'd0);
        check_val("arst_valid",     32'(out_valid),  32'd0);
        check_val("arst_steps",     32'(steps_done), 32'd0);
        check_val("arst_seed",      lfsr_seed,       32'd0);
        check_val("arst_load",      32'(lfsr_load),  32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        e0 = en_count;
        d0 = done_count;
        #1;
        check_val("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_val("post_rst_en",    32'(lfsr_en),   32'd0);
        for (int i = 0; i < 3; i++) tick();
        check_val("post_rst_en_cnt",   en_count - e0,   32'd0);
        check_val("post_rst_done_cnt", done_count - d0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Command-driven sequencer for the n-bit LFSR datapath. It issues seed loads and step enables, and counts bounded step bursts.
- It streams each new LFSR value out over a valid/ready interface and stalls stepping under backpressure.
- It sits between the MMIO register decode (command source) and the LFSR register and polynomial block (load/enable/value).

Parameters:
- N, 32, LFSR width.
- CW, 16, step-count width.

Ports:
- clock  in  1  CCI-P clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  command opcode: 00 STOP, 01 LOAD, 10 STEP_N, 11 RUN.
- cmd_data  in  N  seed for LOAD; count (low CW bits) for STEP_N; ignored otherwise.
- lfsr_load  out  1  one-cycle load strobe to the LFSR.
- lfsr_seed  out  N  seed value, valid while lfsr_load=1.
- lfsr_en  out  1  LFSR advances at every edge where this is 1.
- lfsr_q  in  N  current LFSR value.
- out_valid  out  1  sample available.
- out_ready  in  1  consumer accepts the sample.
- out_data  out  N  equals lfsr_q (combinational).
- busy  out  1  state is LOAD, STEP or RUN.
- done  out  1  one-cycle pulse at the end of STEP_N.
- steps_done  out  CW  steps issued since the last STEP_N/RUN accept; saturates at all-ones.
- lockup  out  1  sticky flag: a step was issued while lfsr_q==0.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including lfsr_seed, steps_done and lockup. The remaining-count register is cleared.
- States are IDLE, LOAD, STEP and RUN.
- cmd_ready is 1 in any of these cases:
  - state IDLE, and cmd_op is not LOAD;
  - state IDLE, cmd_op is LOAD, and out_valid=0;
  - state STEP or RUN, and cmd_op is STOP.
  - In all other cases cmd_ready is 0. The source must hold cmd_op/cmd_data stable while cmd_valid=1 and cmd_ready=0.
- STOP accepted:
  - Next state IDLE; lfsr_en is 0 from the next cycle onward.
  - A pending out_valid sample stays until it is consumed. No done pulse.
  - STOP while in IDLE is accepted and has no effect.
- LOAD accepted:
  - Next state LOAD.
  - In the LOAD cycle: lfsr_load=1, lfsr_seed=registered cmd_data, and lockup is cleared.
  - The following cycle: state IDLE and lfsr_load=0.
- STEP_N accepted:
  - remaining <= cmd_data[CW-1:0]; steps_done <= 0.
  - If the count is nonzero, go to STEP.
  - If the count is 0, stay in IDLE and pulse done in the next cycle; no lfsr_en.
- RUN accepted: steps_done <= 0; go to RUN. No step limit.
- Step condition: lfsr_en = (state==RUN || (state==STEP && remaining!=0)) && (!out_valid || out_ready).
- On each edge with lfsr_en=1:
  - out_valid <= 1.
  - In STEP: remaining decrements.
  - steps_done increments, saturating.
  - If lfsr_q==0: lockup <= 1.
- Edge with out_valid && out_ready && !lfsr_en: out_valid <= 0.
- Throughput: 1 sample per cycle when out_ready is held high. Each sample appears on out_data in the cycle after its lfsr_en edge.
- When remaining goes 1->0: state <= IDLE and done=1 for exactly the next cycle.
- STOP accepted in the same cycle as the final step: the step is still issued and counted. State goes IDLE; done does not pulse.
- steps_done keeps its value in IDLE until the next STEP_N/RUN accept.
- Reset asserted mid-burst: immediate return to the reset values. No further lfsr_en or done.

Test Plan:
- Basic burst:
  - Stimulus: LOAD 0x00000001, then STEP_N 4, out_ready=1.
  - Response: lfsr_load high for 1 cycle with lfsr_seed=0x00000001. Then lfsr_en high for exactly 4 consecutive cycles and 4 out beats matching the golden LFSR model. done pulses once, steps_done=4, then busy=0.
- Backpressure:
  - Stimulus: STEP_N 3; hold out_ready=0 for 5 cycles after the first sample.
  - Response: lfsr_en=0 and out_data stable during the stall. All 3 samples delivered in order; steps_done=3.
- STOP during RUN:
  - Stimulus: RUN, then STOP accepted after 10 steps, out_ready=1.
  - Response: no lfsr_en after the acceptance cycle; steps_done=10 or 11 (the step in the acceptance cycle counts); done never pulses; state IDLE.
- Zero count and command gating:
  - Stimulus: STEP_N 0; then attempt LOAD while out_valid=1.
  - Response: done pulses with no lfsr_en. cmd_ready=0 for the LOAD until the sample is consumed.
- Lockup:
  - Stimulus: LOAD 0x00000000, then STEP_N 2.
  - Response: lockup=1 after the first step and it stays set. A subsequent LOAD 0x00000005 clears it.
- Reset mid-operation:
  - Stimulus: RUN, then reset=0 asynchronously between edges.
  - Response: all outputs 0 immediately. After release, cmd_ready=1 and no lfsr_en until a new command.
